// File: rtl/write_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : write_source_arbiter
// Brief   : Grants one draw source a write pass to the frame manager; the
//           optional watchdog is built when WRITE_SOURCE_WATCHDOG_EN is defined.
// Revision: 1.0
// ============================================================================
module write_source_arbiter #(
   parameter int NUM_SOURCES   = 2,
   parameter int COLOR_DEPTH   = 8,
   parameter int X_W           = 10,
   parameter int Y_W           = 9,
   parameter int SEL_W         = 2,
   parameter int START_TIMEOUT = 1023,
   parameter int WRITE_TIMEOUT = 65535
) (
   input  logic                               clk,
   input  logic                               resetN,
   input  logic                               write_awaited,
   input  logic [SEL_W-1:0]                   write_source_sel,
   input  logic [NUM_SOURCES-1:0]             src_enable,
   input  logic [NUM_SOURCES-1:0]             src_active,
   input  logic [NUM_SOURCES-1:0]             src_transparent,
   input  logic [NUM_SOURCES*COLOR_DEPTH-1:0] src_color,
   input  logic [NUM_SOURCES*X_W-1:0]         src_x,
   input  logic [NUM_SOURCES*Y_W-1:0]         src_y,
   output logic [NUM_SOURCES-1:0]             src_start,
   output logic                               fm_write_active,
   output logic                               fm_write_transparent,
   output logic [COLOR_DEPTH-1:0]             fm_color,
   output logic [X_W-1:0]                     fm_x,
   output logic [Y_W-1:0]                     fm_y,
`ifdef WRITE_SOURCE_WATCHDOG_EN
   output logic [7:0]                         timeout_count,
`endif
   output logic                               busy
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_START       = 3'd1,
      S_WAIT_ACTIVE = 3'd2,
      S_PASS        = 3'd3,
      S_DUMMY       = 3'd4,
      S_ABORT       = 3'd5
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [SEL_W-1:0]         r_grant;
   logic                     r_hist;
   logic                     r_fm_active;
   logic                     r_fm_transp;
   logic                     w_rise;
   logic                     w_start;
   logic                     w_sel_ok;
   logic                     w_sel_active;
   logic                     w_sel_transp;
   logic [COLOR_DEPTH-1:0]   w_sel_color;
   logic [X_W-1:0]           w_sel_x;
   logic [Y_W-1:0]           w_sel_y;
   logic [NUM_SOURCES-1:0]   w_grant_hot;

`ifdef WRITE_SOURCE_WATCHDOG_EN
   logic [31:0]              r_timer;
   logic                     w_timeout;
`else
   logic                     w_unused_cfg;
   assign w_unused_cfg = START_TIMEOUT[0] ^ WRITE_TIMEOUT[0];
`endif

   assign w_rise = write_awaited & ~r_hist;

   // Granted-source mux; an out-of-range grant matches no source and reads as disabled.
   always_comb begin
      w_sel_ok     = 1'b0;
      w_sel_active = 1'b0;
      w_sel_transp = 1'b0;
      w_sel_color  = '0;
      w_sel_x      = '0;
      w_sel_y      = '0;
      w_grant_hot  = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (r_grant == SEL_W'(i)) begin
            w_grant_hot[i] = 1'b1;
            w_sel_ok       = src_enable[i];
            w_sel_active   = src_active[i];
            w_sel_transp   = src_transparent[i];
            w_sel_color    = src_color[i*COLOR_DEPTH +: COLOR_DEPTH];
            w_sel_x        = src_x[i*X_W +: X_W];
            w_sel_y        = src_y[i*Y_W +: Y_W];
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
`ifdef WRITE_SOURCE_WATCHDOG_EN
      w_timeout = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_rise) w_next = S_START;
         end
         S_START: begin
            if (!w_sel_ok) begin
               w_next = S_DUMMY;
            end else begin
               w_start = 1'b1;
               w_next  = S_WAIT_ACTIVE;
            end
         end
         S_WAIT_ACTIVE: begin
            if (w_sel_active) begin
               w_next = S_PASS;
`ifdef WRITE_SOURCE_WATCHDOG_EN
            end else if (r_timer == 32'(START_TIMEOUT - 1)) begin
               w_next    = S_DUMMY;
               w_timeout = 1'b1;
`endif
            end
         end
         S_PASS: begin
            if (!w_sel_active) begin
               w_next = S_IDLE;
`ifdef WRITE_SOURCE_WATCHDOG_EN
            end else if (r_timer == 32'(WRITE_TIMEOUT - 1)) begin
               w_next    = S_ABORT;
               w_timeout = 1'b1;
`endif
            end
         end
         S_DUMMY: w_next = S_IDLE;
         S_ABORT: begin
            if (!w_sel_active) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_hist      <= 1'b0;
         r_fm_active <= 1'b0;
         r_fm_transp <= 1'b0;
         fm_color    <= '0;
         fm_x        <= '0;
         fm_y        <= '0;
      end else begin
         r_state <= w_next;
         r_hist  <= write_awaited;
         if (r_state == S_IDLE && w_rise) r_grant <= write_source_sel;
         // Loading on entry to PASS keeps the first active cycle, giving a pure one-cycle delay.
         r_fm_active <= (w_next == S_PASS) & w_sel_active;
         r_fm_transp <= (w_next == S_PASS) & w_sel_transp;
         if (w_next == S_PASS) begin
            fm_color <= w_sel_color;
            fm_x     <= w_sel_x;
            fm_y     <= w_sel_y;
         end
      end
   end

`ifdef WRITE_SOURCE_WATCHDOG_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_timer       <= '0;
         timeout_count <= '0;
      end else begin
         r_timer <= (w_next == r_state) ? r_timer + 32'd1 : 32'd0;
         if (w_timeout && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
      end
   end
`endif

   assign src_start            = w_start ? w_grant_hot : '0;
   assign fm_write_active      = (r_state == S_DUMMY) | r_fm_active;
   assign fm_write_transparent = (r_state == S_DUMMY) | r_fm_transp;
   assign busy                 = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_write_source_arbiter.sv
`default_nettype none
// Bench for write_source_arbiter: transaction table, random transactions with an
// expected-trace model, and hand sequences for reset and (if built) the watchdog.
module tb_write_source_arbiter;

   logic        clk = 1'b0;
   logic        resetN;
   logic        write_awaited;
   logic [1:0]  write_source_sel;
   logic [1:0]  src_enable, src_active, src_transparent;
   logic [15:0] src_color;
   logic [19:0] src_x;
   logic [17:0] src_y;
   logic [1:0]  src_start;
   logic        fm_write_active, fm_write_transparent;
   logic [7:0]  fm_color;
   logic [9:0]  fm_x;
   logic [8:0]  fm_y;
   logic        busy;
`ifdef WRITE_SOURCE_WATCHDOG_EN
   logic [7:0]  timeout_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] hc [0:63];
   logic [9:0] hx [0:63];
   logic [8:0] hy [0:63];
   logic       ht [0:63];

   typedef struct {
      logic [1:0] sel;
      logic [1:0] en;
      int         lat;
      int         len;
      logic       fixed;
      logic [7:0] col;
      logic [9:0] x;
      logic [8:0] y;
      logic       dummy;
      logic [1:0] start;
   } txn_t;

   write_source_arbiter #(
      .NUM_SOURCES(2), .COLOR_DEPTH(8), .X_W(10), .Y_W(9), .SEL_W(2),
      .START_TIMEOUT(4), .WRITE_TIMEOUT(8)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .write_awaited(write_awaited),
      .write_source_sel(write_source_sel),
      .src_enable(src_enable),
      .src_active(src_active),
      .src_transparent(src_transparent),
      .src_color(src_color),
      .src_x(src_x),
      .src_y(src_y),
      .src_start(src_start),
      .fm_write_active(fm_write_active),
      .fm_write_transparent(fm_write_transparent),
      .fm_color(fm_color),
      .fm_x(fm_x),
      .fm_y(fm_y),
`ifdef WRITE_SOURCE_WATCHDOG_EN
      .timeout_count(timeout_count),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Randomise every source; the granted one gets the requested strobe and its data is logged per slot.
   task automatic drive_src(input int g, input logic gact, input int s, input txn_t t);
      logic [7:0] c;
      logic [9:0] x;
      logic [8:0] y;
      logic       tr;
      for (int i = 0; i < 2; i++) begin
         c  = 8'($urandom);
         x  = 10'($urandom);
         y  = 9'($urandom);
         tr = 1'($urandom);
         if (i == g && t.fixed) begin
            c = t.col; x = t.x; y = t.y; tr = 1'b0;
         end
         src_color[i*8 +: 8]  = c;
         src_x[i*10 +: 10]    = x;
         src_y[i*9 +: 9]      = y;
         src_transparent[i]   = tr;
         if (i == g) begin
            src_active[i] = gact;
            hc[s] = c; hx[s] = x; hy[s] = y; ht[s] = tr;
         end else begin
            src_active[i] = 1'($urandom);
         end
      end
   endtask

   task automatic run_txn(input txn_t t);
      int g;
      int a;
      g = int'(t.sel);
      a = 1 + t.lat;
      write_awaited    = 1'b0;
      write_source_sel = t.sel;
      src_enable       = t.en;
      drive_src(g, 1'b0, 0, t);
      step();
      chk("idle_busy", busy, 0);
      chk("idle_active", fm_write_active, 0);
      chk("idle_start", src_start, 0);
      write_awaited = 1'b1;
      drive_src(g, 1'b0, 0, t);
      step();
      chk("start_pulse", src_start, t.start);
      chk("start_busy", busy, 1);
      chk("start_active", fm_write_active, 0);
      if (t.dummy) begin
         write_source_sel = 2'($urandom);
         write_awaited    = 1'($urandom);
         drive_src(g, 1'b0, 1, t);
         step();
         chk("dummy_active", fm_write_active, 1);
         chk("dummy_transp", fm_write_transparent, 1);
         chk("dummy_start", src_start, 0);
         chk("dummy_busy", busy, 1);
         write_awaited = 1'($urandom);
         src_enable    = 2'($urandom);
         drive_src(g, 1'b0, 2, t);
         step();
         chk("dummy_end_busy", busy, 0);
         chk("dummy_end_active", fm_write_active, 0);
      end else begin
         for (int s = 1; s <= a + t.len; s++) begin
            if (s >= 2) begin
               chk("pass_busy", busy, 1);
               chk("pass_start", src_start, 0);
               if (s >= a + 1) begin
                  chk("pass_active", fm_write_active, 1);
                  chk("pass_color", fm_color, hc[s-1]);
                  chk("pass_x", fm_x, hx[s-1]);
                  chk("pass_y", fm_y, hy[s-1]);
                  chk("pass_transp", fm_write_transparent, ht[s-1]);
               end else begin
                  chk("wait_active", fm_write_active, 0);
               end
            end
            write_source_sel = 2'($urandom);
            write_awaited    = 1'($urandom);
            if (s >= 2) src_enable = 2'($urandom);
            drive_src(g, (s >= a && s < a + t.len), s, t);
            step();
         end
         chk("pass_end_busy", busy, 0);
         chk("pass_end_active", fm_write_active, 0);
      end
   endtask

   txn_t tbl [0:5];
   txn_t rt;

   initial begin
      tbl[0] = '{2'd1, 2'b11, 3, 4, 1'b1, 8'h3C, 10'd5, 9'd7, 1'b0, 2'b10};
      tbl[1] = '{2'd0, 2'b10, 1, 1, 1'b0, 8'h00, 10'd0, 9'd0, 1'b1, 2'b00};
      tbl[2] = '{2'd3, 2'b11, 1, 1, 1'b0, 8'h00, 10'd0, 9'd0, 1'b1, 2'b00};
      tbl[3] = '{2'd2, 2'b11, 1, 1, 1'b0, 8'h00, 10'd0, 9'd0, 1'b1, 2'b00};
      tbl[4] = '{2'd0, 2'b01, 1, 1, 1'b0, 8'h00, 10'd0, 9'd0, 1'b0, 2'b01};
      tbl[5] = '{2'd1, 2'b01, 2, 3, 1'b0, 8'h00, 10'd0, 9'd0, 1'b1, 2'b00};

      resetN = 1'b0;
      write_awaited = 1'b0; write_source_sel = 2'd0;
      src_enable = 2'b00; src_active = 2'b00; src_transparent = 2'b00;
      src_color = '0; src_x = '0; src_y = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_active", fm_write_active, 0);
      chk("rst_transp", fm_write_transparent, 0);
      chk("rst_start", src_start, 0);
      chk("rst_bus", {fm_color, fm_x, fm_y}, 0);
      resetN = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_txn(tbl[i]);

      for (int n = 0; n < 40; n++) begin
         rt.sel   = 2'($urandom_range(0, 3));
         rt.en    = 2'($urandom);
         rt.lat   = int'($urandom_range(1, 5));
         rt.len   = int'($urandom_range(1, 8));
         rt.fixed = 1'b0;
         rt.col = '0; rt.x = '0; rt.y = '0;
         rt.dummy = (rt.sel >= 2'd2) || !rt.en[rt.sel[0]];
         rt.start = rt.dummy ? 2'b00 : (2'b01 << rt.sel);
         run_txn(rt);
      end

      // Reset in the middle of a pass, with the source still active afterwards.
      write_awaited = 1'b0; src_enable = 2'b11; src_active = 2'b00;
      step();
      write_awaited = 1'b1; write_source_sel = 2'd1;
      step();
      src_active = 2'b10;
      step();
      step();
      chk("prerst_active", fm_write_active, 1);
      resetN = 1'b0;
      write_awaited = 1'b0;
      #1;
      chk("midrst_active", fm_write_active, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_bus", {fm_color, fm_x, fm_y, fm_write_transparent, src_start}, 0);
      step();
      resetN = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("postrst_active", fm_write_active, 0);
         chk("postrst_busy", busy, 0);
      end
      src_active = 2'b00;
      step();

`ifdef WRITE_SOURCE_WATCHDOG_EN
      begin
         int highs;
         logic busy_at_20;
         write_awaited = 1'b0; write_source_sel = 2'd1; src_enable = 2'b11; src_active = 2'b00;
         step();
         chk("wd_count0", timeout_count, 0);
         write_awaited = 1'b1;
         step();
         chk("wd_start", src_start, 2'b10);
         step();
         for (int k = 0; k < 4; k++) begin
            chk("wd_wait_active", fm_write_active, 0);
            chk("wd_wait_busy", busy, 1);
            step();
         end
         chk("wd_dummy_active", fm_write_active, 1);
         chk("wd_dummy_transp", fm_write_transparent, 1);
         chk("wd_count1", timeout_count, 1);
         step();
         chk("wd_dummy_end", busy, 0);

         write_awaited = 1'b0;
         step();
         write_awaited = 1'b1;
         step();
         highs = 0;
         busy_at_20 = 1'b0;
         for (int s = 1; s <= 24; s++) begin
            if (s >= 2 && fm_write_active) highs++;
            if (s == 20) busy_at_20 = busy;
            src_active = (s <= 20) ? 2'b10 : 2'b00;
            step();
         end
         chk("wd_write_highs", highs, 8);
         chk("wd_abort_busy", busy_at_20, 1);
         chk("wd_abort_end", busy, 0);
         chk("wd_count2", timeout_count, 2);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
